// File: rtl/seven_seg_reader.sv
// ---------------------------------------------------------------------------
// seven_seg_reader
//
// Purpose:
//   Recovers hexadecimal digit values from a multiplexed 7-segment display
//   bus. This is the inverse of the hex-to-7-segment decoder. The pair
//   {seg_in, dig_sel} is sampled every cycle. A pattern must hold for
//   STABLE_CYCLES consecutive samples before it is accepted as a digit event.
//   One-hot events are assembled into a full multi-digit word. A word is
//   presented once every digit position has been captured at least once.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical samples required (>= 1)
//   DIGITS        - number of multiplexed digit positions (>= 2)
//   IDX_W         - width of the digit index (derived)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   seg_in      in   segment lines a..g on bits 6..0, active-high
//   dig_sel     in   one-hot digit enable, all-zero = blanking/idle
//   digit_valid out  one-cycle pulse per accepted digit event
//   digit_idx   out  index of the accepted digit
//   digit_val   out  decoded nibble
//   digit_err   out  illegal segment pattern or non-one-hot select
//   word_out    out  assembled word, digit k at [4k+3:4k]
//   word_valid  out  one-cycle pulse when word_out takes a complete frame
//   word_err    out  some digit of the completed frame carried an error
// ---------------------------------------------------------------------------
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 3,
    parameter int DIGITS        = 4,
    parameter int IDX_W         = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic                  digit_valid,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [3:0]            digit_val,
    output logic                  digit_err,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  word_valid,
    output logic                  word_err
);

    localparam int                 CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int                 R_W     = 7 + DIGITS;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    // Sample register and stability counter
    logic [R_W-1:0]          r_q, r_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Frame assembly state
    logic [4*DIGITS-1:0]     shadow_q, shadow_d;
    logic [DIGITS-1:0]       mask_q, mask_d;
    logic                    sticky_q, sticky_d;

    // Registered outputs
    logic                    digit_valid_q, digit_valid_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [3:0]              digit_val_q, digit_val_d;
    logic                    digit_err_q, digit_err_d;
    logic [4*DIGITS-1:0]     word_out_q, word_out_d;
    logic                    word_valid_q, word_valid_d;
    logic                    word_err_q, word_err_d;

    // Combinational helpers
    logic [R_W-1:0]          cur_sample;
    logic                    changed;
    logic                    fire;
    logic                    sel_onehot;
    logic [IDX_W-1:0]        sel_idx;
    logic [4:0]              decoded;
    logic [DIGITS-1:0]       mask_new;

    // Segment pattern to {err, nibble}. Unknown patterns decode to 0 with err.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = 5'h00;
            7'h30:   res = 5'h01;
            7'h6D:   res = 5'h02;
            7'h79:   res = 5'h03;
            7'h33:   res = 5'h04;
            7'h5B:   res = 5'h05;
            7'h5F:   res = 5'h06;
            7'h70:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h7B:   res = 5'h09;
            7'h77:   res = 5'h0A;
            7'h1F:   res = 5'h0B;
            7'h4E:   res = 5'h0C;
            7'h3D:   res = 5'h0D;
            7'h4F:   res = 5'h0E;
            7'h47:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    // Stability tracking and event detection. The event condition also accepts
    // a fresh change when STABLE_CYCLES is 1. In that case the counter sits at
    // its maximum and a change lands it there again instead of "transitioning"
    // into it. For larger thresholds, a change always resets the count to 1,
    // so the extra term has no effect.
    always_comb begin
        cur_sample = {seg_in, dig_sel};
        changed    = (cur_sample != r_q);
        r_d        = cur_sample;
        if (changed) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        fire = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX)) && (|dig_sel);
    end

    // Select qualification and binary encoding of the one-hot select. The
    // encoder is only meaningful when the select is one-hot.
    always_comb begin
        sel_onehot = (|dig_sel) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
        sel_idx    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_sel[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
        decoded = decode_seg(seg_in);
    end

    // Event reporting and frame assembly. Digit fields hold between events.
    // Only one-hot events touch the shadow word, the mask and the sticky error.
    // Completing a frame publishes the shadow word including the new nibble.
    always_comb begin
        digit_valid_d = 1'b0;
        digit_idx_d   = digit_idx_q;
        digit_val_d   = digit_val_q;
        digit_err_d   = digit_err_q;
        word_out_d    = word_out_q;
        word_valid_d  = 1'b0;
        word_err_d    = word_err_q;
        shadow_d      = shadow_q;
        mask_d        = mask_q;
        sticky_d      = sticky_q;
        mask_new      = mask_q | dig_sel;

        if (fire) begin
            digit_valid_d = 1'b1;
            if (sel_onehot) begin
                digit_idx_d = sel_idx;
                digit_val_d = decoded[3:0];
                digit_err_d = decoded[4];
                for (int k = 0; k < DIGITS; k++) begin
                    if (dig_sel[k]) begin
                        shadow_d[4*k +: 4] = decoded[3:0];
                    end
                end
                if (mask_new == {DIGITS{1'b1}}) begin
                    word_out_d   = shadow_d;
                    word_err_d   = sticky_q | decoded[4];
                    word_valid_d = 1'b1;
                    mask_d       = '0;
                    sticky_d     = 1'b0;
                end else begin
                    mask_d   = mask_new;
                    sticky_d = sticky_q | decoded[4];
                end
            end else begin
                digit_idx_d = '0;
                digit_val_d = 4'h0;
                digit_err_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q           <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            mask_q        <= '0;
            sticky_q      <= 1'b0;
            digit_valid_q <= 1'b0;
            digit_idx_q   <= '0;
            digit_val_q   <= 4'h0;
            digit_err_q   <= 1'b0;
            word_out_q    <= '0;
            word_valid_q  <= 1'b0;
            word_err_q    <= 1'b0;
        end else begin
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            mask_q        <= mask_d;
            sticky_q      <= sticky_d;
            digit_valid_q <= digit_valid_d;
            digit_idx_q   <= digit_idx_d;
            digit_val_q   <= digit_val_d;
            digit_err_q   <= digit_err_d;
            word_out_q    <= word_out_d;
            word_valid_q  <= word_valid_d;
            word_err_q    <= word_err_d;
        end
    end

    assign digit_valid = digit_valid_q;
    assign digit_idx   = digit_idx_q;
    assign digit_val   = digit_val_q;
    assign digit_err   = digit_err_q;
    assign word_out    = word_out_q;
    assign word_valid  = word_valid_q;
    assign word_err    = word_err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_reader
//
// Purpose:
//   Scoreboard bench for seven_seg_reader with STABLE_CYCLES = 3 and
//   DIGITS = 4. The stimulus tasks push hand-computed digit and word
//   expectations into queues. A negedge monitor pops and compares these
//   entries whenever the DUT pulses digit_valid or word_valid.
// ---------------------------------------------------------------------------
module tb_seven_seg_reader;

    localparam int STABLE_CYCLES = 3;
    localparam int DIGITS        = 4;
    localparam int IDX_W         = 2;

    logic                 clk;
    logic                 rst;
    logic [6:0]           seg_in;
    logic [DIGITS-1:0]    dig_sel;
    logic                 digit_valid;
    logic [IDX_W-1:0]     digit_idx;
    logic [3:0]           digit_val;
    logic                 digit_err;
    logic [4*DIGITS-1:0]  word_out;
    logic                 word_valid;
    logic                 word_err;

    int errors = 0;
    int checks = 0;

    // Expected digit event: {idx, val, err}; expected word: {word, err}
    logic [6:0]  exp_digit_q [$];
    logic [16:0] exp_word_q  [$];

    // Legal patterns in hex-value order
    localparam logic [6:0] PAT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    seven_seg_reader #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .DIGITS        (DIGITS),
        .IDX_W         (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digit_valid (digit_valid),
        .digit_idx   (digit_idx),
        .digit_val   (digit_val),
        .digit_err   (digit_err),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_err    (word_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each output pulse against the head of its queue
    always @(negedge clk) begin
        logic [6:0]  ed;
        logic [16:0] ew;
        if (digit_valid === 1'b1) begin
            checks++;
            if (exp_digit_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL digit_unexpected t=%0t got idx=%0d val=%h err=%b, required no event",
                         $time, digit_idx, digit_val, digit_err);
            end else begin
                ed = exp_digit_q.pop_front();
                if ({digit_idx, digit_val, digit_err} !== ed) begin
                    errors++;
                    $display("[TB] FAIL digit_event t=%0t got idx=%0d val=%h err=%b, required idx=%0d val=%h err=%b",
                             $time, digit_idx, digit_val, digit_err, ed[6:5], ed[4:1], ed[0]);
                end
            end
        end
        if (word_valid === 1'b1) begin
            checks++;
            if (exp_word_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL word_unexpected t=%0t got word=%h err=%b, required no word",
                         $time, word_out, word_err);
            end else begin
                ew = exp_word_q.pop_front();
                if ({word_out, word_err} !== ew) begin
                    errors++;
                    $display("[TB] FAIL word_event t=%0t got word=%h err=%b, required word=%h err=%b",
                             $time, word_out, word_err, ew[16:1], ew[0]);
                end
            end
        end
    end

    // Direct comparison of a sampled value against a required value
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s got %h, required %h", name, actual, required);
        end
    endtask

    // Drive a pattern for a number of cycles, optionally expecting one event
    task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles,
                                 input bit fire, input logic [1:0] idx, input logic [3:0] val,
                                 input bit err);
        if (fire) exp_digit_q.push_back({idx, val, err});
        dig_sel = sel;
        seg_in  = seg;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        applyStimulus(4'b0000, 7'h00, cycles, 1'b0, 2'd0, 4'h0, 1'b0);
    endtask

    task automatic expectWord(input logic [15:0] w, input bit err);
        exp_word_q.push_back({w, err});
    endtask

    // Reset for two cycles with random inputs, then check cleared outputs
    task automatic doReset(input string tag);
        rst     = 1'b1;
        seg_in  = 7'($urandom);
        dig_sel = 4'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            seg_in  = 7'($urandom);
            dig_sel = 4'($urandom);
        end
        checkOutput({tag, "_digit_valid"}, 16'(digit_valid), 16'h0);
        checkOutput({tag, "_digit_idx"},   16'(digit_idx),   16'h0);
        checkOutput({tag, "_digit_val"},   16'(digit_val),   16'h0);
        checkOutput({tag, "_digit_err"},   16'(digit_err),   16'h0);
        checkOutput({tag, "_word_out"},    word_out,         16'h0);
        checkOutput({tag, "_word_valid"},  16'(word_valid),  16'h0);
        checkOutput({tag, "_word_err"},    16'(word_err),    16'h0);
        rst     = 1'b0;
        seg_in  = 7'h00;
        dig_sel = 4'b0000;
    endtask

    initial begin
        rst     = 1'b1;
        seg_in  = 7'h00;
        dig_sel = 4'b0000;
        doReset("reset");
        idle(4);

        // Single digit held 6 cycles: exactly one event
        applyStimulus(4'b0001, 7'h6D, 6, 1'b1, 2'd0, 4'h2, 1'b0);
        idle(2);

        // Glitch rejection on digit 1
        applyStimulus(4'b0010, 7'h5B, 2, 1'b0, 2'd0, 4'h0, 1'b0);
        applyStimulus(4'b0010, 7'h5F, 3, 1'b1, 2'd1, 4'h6, 1'b0);
        idle(2);

        // Full frame 3, A, C, 1
        applyStimulus(4'b0001, 7'h79, 4, 1'b1, 2'd0, 4'h3, 1'b0);
        applyStimulus(4'b0010, 7'h77, 4, 1'b1, 2'd1, 4'hA, 1'b0);
        applyStimulus(4'b0100, 7'h4E, 4, 1'b1, 2'd2, 4'hC, 1'b0);
        expectWord(16'h1CA3, 1'b0);
        applyStimulus(4'b1000, 7'h30, 4, 1'b1, 2'd3, 4'h1, 1'b0);
        idle(2);

        // Errors: illegal pattern, non-one-hot select (not stored), error frame.
        // Digit 0 is captured last, so a stored non-one-hot event would complete early.
        applyStimulus(4'b0100, 7'h00, 3, 1'b1, 2'd2, 4'h0, 1'b1);
        applyStimulus(4'b0011, 7'h6D, 3, 1'b1, 2'd0, 4'h0, 1'b1);
        applyStimulus(4'b0010, 7'h30, 3, 1'b1, 2'd1, 4'h1, 1'b0);
        applyStimulus(4'b1000, 7'h7F, 3, 1'b1, 2'd3, 4'h8, 1'b0);
        expectWord(16'h801E, 1'b1);
        applyStimulus(4'b0001, 7'h4F, 3, 1'b1, 2'd0, 4'hE, 1'b0);
        idle(2);
        checkOutput("word_hold", word_out, 16'h801E);

        // Exhaustive decode on digit 0, with idle gaps and a reset mid-sequence
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0001, PAT[i], 3, 1'b1, 2'd0, 4'(i), 1'b0);
            idle(2);
        end
        applyStimulus(4'b0010, 7'h77, 3, 1'b1, 2'd1, 4'hA, 1'b0);
        applyStimulus(4'b0100, 7'h4E, 3, 1'b1, 2'd2, 4'hC, 1'b0);
        doReset("midreset");
        idle(2);
        for (int i = 8; i < 16; i++) begin
            applyStimulus(4'b0001, PAT[i], 3, 1'b1, 2'd0, 4'(i), 1'b0);
            idle(2);
        end
        // The partial frame was discarded, so digit 3 alone does not complete
        applyStimulus(4'b1000, 7'h30, 3, 1'b1, 2'd3, 4'h1, 1'b0);
        applyStimulus(4'b0010, 7'h5B, 3, 1'b1, 2'd1, 4'h5, 1'b0);
        expectWord(16'h165F, 1'b0);
        applyStimulus(4'b0100, 7'h5F, 3, 1'b1, 2'd2, 4'h6, 1'b0);
        idle(6);

        // Every expected event must have been consumed
        checkOutput("digit_queue_empty", 16'(exp_digit_q.size()), 16'h0);
        checkOutput("word_queue_empty",  16'(exp_word_q.size()),  16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Recovers hexadecimal digit values from a multiplexed 7-segment display bus. This is the inverse of the team's hex-to-7-segment decoder. The block samples the segment lines together with the one-hot digit-select lines and waits for each pattern to be stable before reporting a per-digit nibble event. It also assembles a full multi-digit word once every digit position has been captured. It sits on the monitor/loopback side of the display path, where it checks display drivers and feeds captured values back into the design.

## Interface
- `STABLE_CYCLES`, default 3: consecutive identical samples (≥1) required before a pattern is accepted.
- `DIGITS`, default 4: number of multiplexed digit positions (≥2).
- `IDX_W`, default `$clog2(DIGITS)`: width of the digit index (derived).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seg_in`  in  7  segment lines, active-high; bit 6 = a, bit 5 = b, through bit 0 = g.
- `dig_sel`  in  `DIGITS`  one-hot digit enable; bit k selects digit k; all-zero = blanking/idle.
- `digit_valid`  out  1  one-cycle pulse: an accepted digit event.
- `digit_idx`  out  `IDX_W`  index of the accepted digit.
- `digit_val`  out  4  decoded nibble.
- `digit_err`  out  1  accepted event carried an illegal pattern or a non-one-hot select.
- `word_out`  out  `4*DIGITS`  assembled word; digit k sits at `[4k+3:4k]`.
- `word_valid`  out  1  one-cycle pulse: `word_out` updated with a complete frame.
- `word_err`  out  1  one or more digits of the frame just completed had `digit_err`; valid with `word_valid`.

## Operation
- **Legal patterns** (hex value = pattern): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47.
- **Any other pattern:** `digit_val` = 0 and `digit_err` = 1.
- **Sample register `r`** holds the pair {`seg_in`, `dig_sel`}. Counter `cnt` spans 0..`STABLE_CYCLES`. On each edge:
  - `r` <= the current input.
  - If input ≠ `r`, `cnt` <= 1; otherwise `cnt` <= min(`cnt`+1, `STABLE_CYCLES`).
- **Event:** fires on the edge where `cnt` transitions into `STABLE_CYCLES`, and only if `dig_sel` ≠ 0. There is exactly one event per stable period. Holding a value indefinitely never re-fires.
- **Idle:** `dig_sel` = 0 never produces an event; the counter keeps running.
- **Non-one-hot select (≥2 bits set):** event with `digit_err` = 1, `digit_idx` = 0, `digit_val` = 0. This event is not stored into the frame.
- **Frame assembly:** uses a shadow word, a capture mask of `DIGITS` bits, and a sticky error bit.
  - On a one-hot event for digit k: write the nibble into shadow slot k, set mask bit k, and OR `digit_err` into the sticky error bit.
  - A repeated digit before completion overwrites its slot; the mask is unchanged.
  - When an event sets the last missing mask bit:
    - `word_out` <= shadow including the new nibble.
    - `word_err` <= sticky error OR'd with this event's error.
    - `word_valid` pulses.
    - Mask and sticky error clear.
- **Reset:** clears `r`, `cnt`, mask, shadow and sticky error. All outputs go to 0: `digit_valid`, `digit_idx`, `digit_val`, `digit_err`, `word_out`, `word_valid`, `word_err`. Reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- **Event latency:** input is presented before edge 1 and held. The event occurs at edge `STABLE_CYCLES`, so `digit_valid` is high in the cycle after edge `STABLE_CYCLES`.
- `digit_idx`, `digit_val` and `digit_err` hold their last event's values between pulses.
- `word_valid` is asserted in the same cycle as the `digit_valid` of the completing digit. `word_out` and `word_err` hold until the next completion.
- **After reset deassert:** a value already present on the inputs needs the full `STABLE_CYCLES` edges. `r` resets to 0, which is idle, so any non-idle input counts as a change.
- **`STABLE_CYCLES` = 1:** every change to a non-idle value produces an event on the first edge.
- **Glitches:** any change, including a single-cycle glitch, restarts the count at 1.
- **Throughput:** at most one event per `STABLE_CYCLES` cycles.

## Test plan
All scenarios use `STABLE_CYCLES` = 3 and `DIGITS` = 4.
- **Reset:** hold `rst` for 2 cycles with random inputs -> all outputs 0, no pulses during reset.
- **Single digit:** `dig_sel` = 0001, `seg_in` = 6D held 6 cycles -> exactly one `digit_valid` after edge 3, `digit_idx` = 0, `digit_val` = 2, `digit_err` = 0; no `word_valid`.
- **Glitch rejection:** 5B held 2 cycles, then 5F held 3 cycles on digit 1 -> a single event, `digit_val` = 6, `digit_idx` = 1.
- **Full frame:** digits 0..3 driven with 79, 77, 4E, 30, each held 4 cycles -> four events (3, A, C, 1); `word_valid` coincides with the 4th `digit_valid`; `word_out` = 16'h1CA3, `word_err` = 0.
- **Errors:**
  - Digit 2 with `seg_in` = 00 -> `digit_err` = 1, `digit_val` = 0.
  - `dig_sel` = 0011 -> `digit_err` = 1, `digit_idx` = 0, no frame write.
  - Completing the frame -> `word_err` = 1.
- **Exhaustive decode and idle:** all 16 legal patterns on digit 0, each held 3 cycles, separated by 2 idle cycles (`dig_sel` = 0) -> `digit_val` 0..F in order, no events during idle; reset asserted mid-sequence aborts cleanly.
